// File: rtl/ioshim_iosched_if.sv
// Core-side request/response bus of ioshim_iosched.
// The core drives the master modport; the scheduler is the slave.
interface ioshim_iosched_if #(
  parameter int PORTW = 2
);
  logic             io_req;
  logic [PORTW-1:0] io_port;
  logic [7:0]       io_dout1;
  logic [7:0]       io_dout2;
  logic [15:0]      io_ab_dout;
  logic             io_busy;
  logic             io_done;
  logic             io_err;
  logic             io_wreg;
  logic             io_wa;
  logic             io_wb;
  logic [7:0]       io_din;
  logic [15:0]      io_ab_din;

  modport master (
    output io_req, io_port, io_dout1, io_dout2, io_ab_dout,
    input  io_busy, io_done, io_err, io_wreg, io_wa, io_wb, io_din, io_ab_din
  );

  modport slave (
    input  io_req, io_port, io_dout1, io_dout2, io_ab_dout,
    output io_busy, io_done, io_err, io_wreg, io_wa, io_wb, io_din, io_ab_din
  );
endinterface

// File: rtl/ioshim_iosched.sv
// Shares one ioshim I/O slot between NPORTS peripherals: strobe, wait for writeback or timeout, mux back.
// Optional error counter enabled by defining IOSHIM_IOSCHED_ERRCNT_EN.
module ioshim_iosched #(
  parameter int NPORTS  = 4,
  parameter int PORTW   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  ioshim_iosched_if.slave       io,
  output logic [7:0]            err_count,
  output logic [NPORTS-1:0]     per_en,
  output logic [7:0]            per_dout1,
  output logic [7:0]            per_dout2,
  output logic [15:0]           per_ab_dout,
  input  logic [NPORTS-1:0]     per_wreg,
  input  logic [NPORTS-1:0]     per_wa,
  input  logic [NPORTS-1:0]     per_wb,
  input  logic [8*NPORTS-1:0]   per_din,
  input  logic [16*NPORTS-1:0]  per_ab_din
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  localparam logic [PORTW:0] NPORTS_W = (PORTW+1)'(NPORTS);
  localparam logic [7:0]     CNT_LAST = 8'(TIMEOUT-1);

  state_t           state, state_nx;
  logic [PORTW-1:0] port_q;
  logic [7:0]       cnt_q;
  logic             err_q, wreg_q, wa_q, wb_q;
  logic [7:0]       din_q;
  logic [15:0]      ab_din_q;

  logic             sel_wreg, sel_wa, sel_wb;
  logic [7:0]       sel_din;
  logic [15:0]      sel_ab_din;
  logic             port_ok, resp, timeout;

  assign port_ok = {1'b0, io.io_port} < NPORTS_W;
  assign resp    = sel_wreg | sel_wa | sel_wb;
  assign timeout = cnt_q == CNT_LAST;

  // Loop-based mux keeps the index in range when NPORTS < 2**PORTW.
  always_comb begin
    sel_wreg   = 1'b0;
    sel_wa     = 1'b0;
    sel_wb     = 1'b0;
    sel_din    = '0;
    sel_ab_din = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (port_q == PORTW'(i)) begin
        sel_wreg   = per_wreg[i];
        sel_wa     = per_wa[i];
        sel_wb     = per_wb[i];
        sel_din    = per_din[8*i +: 8];
        sel_ab_din = per_ab_din[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    per_en     = '0;
    io.io_busy = state != IDLE;
    io.io_done = state == DONE;
    io.io_err  = 1'b0;
    io.io_wreg = 1'b0;
    io.io_wa   = 1'b0;
    io.io_wb   = 1'b0;
    case (state)
      IDLE:   if (io.io_req) state_nx = port_ok ? STROBE : DONE;
      STROBE: begin
        state_nx = WAIT;
        for (int unsigned i = 0; i < NPORTS; i++)
          per_en[i] = port_q == PORTW'(i);
      end
      WAIT:   if (resp || timeout) state_nx = DONE;
      DONE: begin
        state_nx   = IDLE;
        io.io_err  = err_q;
        io.io_wreg = wreg_q;
        io.io_wa   = wa_q;
        io.io_wb   = wb_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wreg_q      <= 1'b0;
      wa_q        <= 1'b0;
      wb_q        <= 1'b0;
      din_q       <= '0;
      ab_din_q    <= '0;
      per_dout1   <= '0;
      per_dout2   <= '0;
      per_ab_dout <= '0;
    end else begin
      case (state)
        IDLE: if (io.io_req) begin
          port_q      <= io.io_port;
          per_dout1   <= io.io_dout1;
          per_dout2   <= io.io_dout2;
          per_ab_dout <= io.io_ab_dout;
          err_q       <= !port_ok;
          wreg_q      <= 1'b0;
          wa_q        <= 1'b0;
          wb_q        <= 1'b0;
        end
        STROBE: cnt_q <= '0;
        WAIT: begin
          if (resp) begin
            err_q    <= 1'b0;
            wreg_q   <= sel_wreg;
            wa_q     <= sel_wa;
            wb_q     <= sel_wb;
            din_q    <= sel_din;
            ab_din_q <= sel_ab_din;
          end else if (timeout) begin
            err_q  <= 1'b1;
            wreg_q <= 1'b0;
            wa_q   <= 1'b0;
            wb_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.io_din    = din_q;
  assign io.io_ab_din = ab_din_q;

`ifdef IOSHIM_IOSCHED_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if (state == DONE && err_q && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ioshim_iosched.sv
// Scoreboard bench for ioshim_iosched: timed peripheral stimulus, expected completions queued, monitor compares.
`timescale 1ns/1ps
module tb_ioshim_iosched;
  localparam int NPORTS  = 3;
  localparam int PORTW   = 2;
  localparam int TIMEOUT = 4;
`ifdef IOSHIM_IOSCHED_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           err_count;
  logic [NPORTS-1:0]    per_en;
  logic [7:0]           per_dout1, per_dout2;
  logic [15:0]          per_ab_dout;
  logic [NPORTS-1:0]    per_wreg, per_wa, per_wb;
  logic [8*NPORTS-1:0]  per_din;
  logic [16*NPORTS-1:0] per_ab_din;

  ioshim_iosched_if #(.PORTW(PORTW)) bus();

  ioshim_iosched #(.NPORTS(NPORTS), .PORTW(PORTW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .io(bus), .err_count(err_count),
    .per_en(per_en), .per_dout1(per_dout1), .per_dout2(per_dout2),
    .per_ab_dout(per_ab_dout), .per_wreg(per_wreg), .per_wa(per_wa),
    .per_wb(per_wb), .per_din(per_din), .per_ab_din(per_ab_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    logic        err, wreg, wa, wb;
    logic [7:0]  din;
    logic [15:0] ab;
    int          cnt_after;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [7:0]        m_din = '0;
  logic [15:0]       m_ab  = '0;
  int                m_errs = 0;
  int                exp_en_cyc = -10;
  logic [NPORTS-1:0] exp_en_val = '0;
  logic [NPORTS-1:0] en_exp;
  bit                cnt_pending = 0;
  int                cnt_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    en_exp = (cyc == exp_en_cyc) ? exp_en_val : '0;
    check("per_en", 32'(per_en), 32'(en_exp));
    if (cnt_pending) begin
      check("err_count", 32'(err_count), 32'(cnt_exp));
      cnt_pending = 0;
    end
    if (bus.io_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got io_done=1 expected none (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        check("done_cycle", cyc, me.done_cyc);
        check("io_err", 32'(bus.io_err), 32'(me.err));
        check("flags", {29'd0, bus.io_wreg, bus.io_wa, bus.io_wb}, {29'd0, me.wreg, me.wa, me.wb});
        check("io_din", 32'(bus.io_din), 32'(me.din));
        check("io_ab_din", 32'(bus.io_ab_din), 32'(me.ab));
        cnt_exp     = me.cnt_after;
        cnt_pending = 1;
      end
    end else begin
      check("idle_flags", {28'd0, bus.io_err, bus.io_wreg, bus.io_wa, bus.io_wb}, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_core"}, {26'd0, bus.io_busy, bus.io_done, bus.io_err, bus.io_wreg, bus.io_wa, bus.io_wb}, 32'd0);
    check({tag, "_din"}, {8'd0, bus.io_din, bus.io_ab_din}, 32'd0);
    check({tag, "_per"}, 32'({per_en, per_dout1, per_dout2}), 32'd0);
    check({tag, "_per_ab"}, 32'(per_ab_dout), 32'd0);
    check({tag, "_errcnt"}, 32'(err_count), 32'd0);
  endtask

  task automatic idle_inputs();
    bus.io_req = 1'b0;
    per_wreg = '0; per_wa = '0; per_wb = '0;
    per_din = '0; per_ab_din = '0;
  endtask

  // Peripheral `port` answers with flags fl d cycles after its per_en cycle (d > TIMEOUT = silent).
  task automatic do_txn(input int port, input int d, input logic [2:0] fl, input logic [7:0] din,
                        input logic [15:0] ab, input bit stray, input bit dummy);
    exp_t e;
    int t0, last, dummy_o;
    bit ok, hit;
    logic [7:0] op1, op2;
    logic [15:0] abop;
    t0   = cyc;
    ok   = port < NPORTS;
    hit  = ok && d <= TIMEOUT;
    op1  = 8'($urandom);
    op2  = 8'($urandom);
    abop = 16'($urandom);
    last = !ok ? 1 : (hit ? 2 + d : 2 + TIMEOUT);
    e.done_cyc = t0 + last;
    e.err  = !hit;
    e.wreg = hit & fl[2];
    e.wa   = hit & fl[1];
    e.wb   = hit & fl[0];
    if (hit) begin
      m_din = din;
      m_ab  = ab;
    end
    e.din = m_din;
    e.ab  = m_ab;
    if (!hit && ERRCNT && m_errs < 255) m_errs++;
    e.cnt_after = m_errs;
    q.push_back(e);
    if (ok) begin
      exp_en_cyc = t0 + 1;
      exp_en_val = NPORTS'(1) << port;
    end
    dummy_o = dummy ? int'($urandom_range(1, last)) : -1;
    for (int o = 0; o <= last; o++) begin
      bus.io_req  = (o == 0) || (o == dummy_o);
      bus.io_port = (o == 0) ? PORTW'(port) : PORTW'($urandom);
      bus.io_dout1   = (o == 0) ? op1 : 8'($urandom);
      bus.io_dout2   = (o == 0) ? op2 : 8'($urandom);
      bus.io_ab_dout = (o == 0) ? abop : 16'($urandom);
      per_din    = (8*NPORTS)'({$urandom, $urandom});
      per_ab_din = (16*NPORTS)'({$urandom, $urandom});
      if (stray) begin
        per_wreg = NPORTS'($urandom) | ((port != 0) ? NPORTS'(1) : '0);
        per_wa   = NPORTS'($urandom);
        per_wb   = NPORTS'($urandom);
      end else begin
        per_wreg = '0; per_wa = '0; per_wb = '0;
      end
      // selected port must be quiet during WAIT except in its answer cycle
      if (ok && o >= 2 && o < last) begin
        per_wreg[port] = 1'b0;
        per_wa[port]   = 1'b0;
        per_wb[port]   = 1'b0;
      end
      if (hit && o == 1 + d) begin
        per_wreg[port] = fl[2];
        per_wa[port]   = fl[1];
        per_wb[port]   = fl[0];
        per_din[8*port +: 8]     = din;
        per_ab_din[16*port +: 16] = ab;
      end
      if (o == 1) begin
        check("per_dout1", 32'(per_dout1), 32'(op1));
        check("per_dout2", 32'(per_dout2), 32'(op2));
        check("per_ab_dout", 32'(per_ab_dout), 32'(abop));
      end
      if (o >= 1) check("io_busy", 32'(bus.io_busy), 32'd1);
      @(posedge clk); #1;
    end
    idle_inputs();
    check("idle_busy", 32'(bus.io_busy), 32'd0);
  endtask

  task automatic do_reset_mid();
    int t0;
    t0 = cyc;
    exp_en_cyc = t0 + 1;
    exp_en_val = NPORTS'(1) << 1;
    bus.io_req = 1'b1;
    bus.io_port = PORTW'(1);
    bus.io_dout1 = 8'h11; bus.io_dout2 = 8'h22; bus.io_ab_dout = 16'h3344;
    @(posedge clk); #1;
    bus.io_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    per_wreg[1] = 1'b1;
    per_din[15:8] = 8'h3C;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    check_all_zero("mid_reset");
    m_din = '0;
    m_ab = '0;
    m_errs = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.io_port = '0; bus.io_dout1 = '0; bus.io_dout2 = '0; bus.io_ab_dout = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("post_reset");

    do_txn(1, 1, 3'b100, 8'hA5, 16'h5AA5, 0, 0);   // registered gpio answer
    do_txn(2, 99, 3'b111, 8'hFF, 16'hFFFF, 0, 0);  // silent port, timeout
    do_txn(3, 1, 3'b111, 8'h77, 16'h7777, 0, 0);   // bad port
    do_txn(1, 2, 3'b010, 8'h5C, 16'hBEEF, 1, 1);   // busy req + stray responses
    do_txn(0, TIMEOUT, 3'b001, 8'hC3, 16'h0F0F, 1, 0);
    do_txn(2, TIMEOUT + 1, 3'b101, 8'h99, 16'h1111, 1, 1);
    do_reset_mid();
    do_txn(1, 1, 3'b110, 8'h42, 16'h4242, 0, 0);

    for (int n = 0; n < 150; n++)
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 3'($urandom_range(1, 7)),
             8'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

    for (int n = 0; n < 260; n++)
      do_txn(3, 1, 3'b111, 8'h00, 16'h0000, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("err_count_final", 32'(err_count), ERRCNT ? 32'd255 : 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
